vx_index_arbiter: RTL and testbench
===================================

Name: VX_index_arbiter

Overview:
- Shares one tag-indexed slot table among NUM_REQS requesters.
- Each granted request gets a free slot index (tag); the requester id and payload are stored under that tag and forwarded downstream with it.
- The returning response carries the tag. The block looks up the stored entry, routes it back with the requester id, and frees the slot.
- Sits in front of memory/cache request paths where out-of-order responses must be matched to their originators.

Parameters:
- NUM_REQS, 4, number of requesters (>=1)
- DATAW, 8, payload width per request
- SIZE, 4, number of slots/tags (>=2)
- ADDRW, `LOG2UP(SIZE), tag width (derived)
- REQW, `LOG2UP(NUM_REQS), requester id width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQS  per-requester request valid
- req_data  in  NUM_REQS*DATAW  per-requester payload
- req_ready  out  NUM_REQS  per-requester accept (one-hot or zero)
- out_valid  out  1  downstream request valid
- out_data  out  DATAW  granted payload
- out_tag  out  ADDRW  allocated slot index
- out_ready  in  1  downstream accept
- rsp_valid  in  1  returning response valid
- rsp_tag  in  ADDRW  tag of returning response
- rsp_ready  out  1  response accept
- rsp_out_valid  out  1  routed response valid
- rsp_out_data  out  DATAW  payload stored at allocation
- rsp_out_idx  out  REQW  originating requester id
- rsp_out_ready  in  1  routed response accept
- empty  out  1  no slot allocated
- full  out  1  all slots allocated
- count  out  ADDRW+1  number of allocated slots

Behaviour:
- Reset (sync, high): clears occupancy bitmap, RR pointer=0, out_valid=0, rsp_out_valid=0, empty=1, full=0, count=0. All outputs reach these values one edge after reset asserts. Reset mid-operation drops in-flight stages and frees every slot. Table contents are don't-care.
- Grant condition: any req_valid, and !full, and (!out_valid || out_ready).
- Arbitration: round-robin. Search starts at the RR pointer. On grant, the pointer becomes (granted index+1) mod NUM_REQS. req_ready is one-hot on the granted index, else all zero.
- Allocation: the lowest-numbered free slot in the current bitmap. On the grant edge:
  - table[slot] <= {granted id, req_data}
  - slot marked busy
  - out stage loads out_data/out_tag, out_valid=1
  - Request latency is 1 cycle (grant at edge N, out_valid from N+1).
- Out stage: holds while out_valid && !out_ready. It clears on out_ready unless a new grant reloads it the same cycle, so full throughput is 1 per cycle.
- rsp_ready = !rsp_out_valid || rsp_out_ready. This is a combinational function of the output stage only.
- Response handshake (rsp_valid && rsp_ready) at edge N:
  - rsp_out stage loads table[rsp_tag]
  - slot rsp_tag freed
  - rsp_out_valid=1 from N+1 (1-cycle latency)
  - Read is of the stored entry; the table is write-before-read only for different slots.
- Simultaneous allocate and release: both take effect at the same edge.
  - count += 1, count -= 1, or unchanged, as appropriate.
  - full/empty/count are registered and reflect post-edge state.
  - A slot released at edge N is not allocatable until N+1, so a full buffer with a release pending does not grant that cycle.
- Wrap-around: tags are reused in lowest-free order, with no FIFO ordering requirement.
- Release of a non-busy tag is an assertion error in simulation. In RTL it is ignored: no count change, rsp_out still produced with stale data.
- count never exceeds SIZE and never underflows.
- full = (count==SIZE), empty = (count==0).

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, out_valid=0, rsp_ready=1.
- NUM_REQS=4, all req_valid=1 continuously, out_ready=1, responses withheld:
  - Grants go 0,1,2,3 with tags 0,1,2,3.
  - After 4 grants, full=1, count=4, req_ready=0.
- Full buffer; rsp_tag=2 accepted at cycle N:
  - rsp_out_idx=2 and rsp_out_data equals the payload of requester 2, at N+1.
  - No grant at N; next grant at N+1 receives tag 2.
- Back-pressure: out_ready=0 for 3 cycles with req0 valid:
  - out_valid stays 1, out_tag/out_data stable.
  - No second grant; count=1.
- Same-cycle allocate of tag 1 and release of tag 0 with count=1 -> count stays 1, empty=0; next allocate gets tag 0.
- Reset asserted with count=3 and rsp_out_valid=1 -> next cycle count=0, empty=1, rsp_out_valid=0, out_valid=0, RR pointer=0.

Source files
------------

// File: rtl/vx_index_arbiter.sv
// rtl/vx_index_arbiter.sv - round-robin request arbiter with a tag-indexed slot table
//
// Purpose:
//   Grants one of NUM_REQS requesters per cycle, allocates the lowest free
//   slot (tag), stores {requester id, payload} under that tag and forwards
//   the payload downstream with the tag. A returning response carries the
//   tag; the stored entry is routed back with the requester id and the slot
//   is freed.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_data/req_ready    per-requester request channel
//   out_valid/out_data/out_tag      downstream request channel
//   out_ready                       downstream accept
//   rsp_valid/rsp_tag/rsp_ready     returning response channel
//   rsp_out_valid/data/idx/ready    routed response channel
//   empty/full/count                slot occupancy status

module vx_index_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 8,
  parameter int SIZE     = 4,
  localparam int ADDRW   = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int REQW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic [ADDRW-1:0]          out_tag,
  input  logic                      out_ready,
  input  logic                      rsp_valid,
  input  logic [ADDRW-1:0]          rsp_tag,
  output logic                      rsp_ready,
  output logic                      rsp_out_valid,
  output logic [DATAW-1:0]          rsp_out_data,
  output logic [REQW-1:0]           rsp_out_idx,
  input  logic                      rsp_out_ready,
  output logic                      empty,
  output logic                      full,
  output logic [ADDRW:0]            count
);

  localparam int ENTW = REQW + DATAW;

  logic [SIZE-1:0]  busy;
  logic [SIZE-1:0]  busy_next;
  logic [REQW-1:0]  rr_ptr;
  logic [ADDRW:0]   count_q;
  logic [ENTW-1:0]  slot_table [SIZE];

  logic             found;
  logic [REQW-1:0]  grant_idx;
  logic [ADDRW-1:0] free_idx;
  logic             grant;
  logic             rsp_fire;
  logic             rel_ok;
  logic [DATAW-1:0] grant_data;

  // Round-robin search starting at rr_ptr.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!found && req_valid[(int'(rr_ptr) + i) % NUM_REQS]) begin
        found     = 1'b1;
        grant_idx = REQW'((int'(rr_ptr) + i) % NUM_REQS);
      end
    end
  end

  // Lowest free slot; descending scan so the smallest index wins.
  always_comb begin
    free_idx = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = ADDRW'(i);
    end
  end

  assign full       = (count_q == (ADDRW+1)'(SIZE));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign grant      = found && !full && (!out_valid || out_ready);
  assign grant_data = req_data[int'(grant_idx)*DATAW +: DATAW];
  assign rsp_ready  = !rsp_out_valid || rsp_out_ready;
  assign rsp_fire   = rsp_valid && rsp_ready;
  // Releasing a slot that is not allocated must not disturb occupancy.
  assign rel_ok     = rsp_fire && busy[rsp_tag];

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  // Release and allocation never target the same slot: allocation only
  // picks a free slot and release only acts on a busy one.
  always_comb begin
    busy_next = busy;
    if (rel_ok) busy_next[rsp_tag] = 1'b0;
    if (grant)  busy_next[free_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy          <= '0;
      rr_ptr        <= '0;
      count_q       <= '0;
      out_valid     <= 1'b0;
      rsp_out_valid <= 1'b0;
    end else begin
      busy <= busy_next;
      case ({grant, rel_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (grant) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_tag   <= free_idx;
        rr_ptr    <= REQW'((int'(grant_idx) + 1) % NUM_REQS);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (rsp_fire) begin
        rsp_out_valid                <= 1'b1;
        {rsp_out_idx, rsp_out_data}  <= slot_table[rsp_tag];
      end else if (rsp_out_ready) begin
        rsp_out_valid <= 1'b0;
      end
    end
  end

  // Table contents are never reset; only the busy bitmap gives them meaning.
  always_ff @(posedge clk) begin
    if (grant) slot_table[free_idx] <= {grant_idx, grant_data};
  end

  release_busy_tag : assert property (@(posedge clk) disable iff (reset)
    rsp_fire |-> busy[rsp_tag]);

endmodule

// File: tb/tb_vx_index_arbiter.sv
// tb/tb_vx_index_arbiter.sv - scoreboard bench for vx_index_arbiter
module tb_vx_index_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int SZ = 4;
  localparam int AW = 2;
  localparam int RW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic           out_valid;
  logic [DW-1:0]  out_data;
  logic [AW-1:0]  out_tag;
  logic           out_ready;
  logic           rsp_valid;
  logic [AW-1:0]  rsp_tag;
  logic           rsp_ready;
  logic           rsp_out_valid;
  logic [DW-1:0]  rsp_out_data;
  logic [RW-1:0]  rsp_out_idx;
  logic           rsp_out_ready;
  logic           empty;
  logic           full;
  logic [AW:0]    count;

  always #5 clk = ~clk;

  vx_index_arbiter #(.NUM_REQS(NR), .DATAW(DW), .SIZE(SZ)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag), .out_ready(out_ready),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
    .rsp_out_valid(rsp_out_valid), .rsp_out_data(rsp_out_data), .rsp_out_idx(rsp_out_idx),
    .rsp_out_ready(rsp_out_ready),
    .empty(empty), .full(full), .count(count)
  );

  typedef struct {
    int a;
    int b;
  } ent_t;

  ent_t oq[$];
  ent_t rq[$];
  bit   mbusy [SZ];
  int   mt_idx [SZ];
  int   mt_dat [SZ];
  int   mcnt;
  int   mrr;
  int   vectors;
  int   miscompares;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < SZ; i++) mbusy[i] = 1'b0;
    mcnt = 0;
    mrr  = 0;
    oq.delete();
    rq.delete();
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, oq.size() != 0);
    if (oq.size() != 0) begin
      check("out_tag", out_tag, oq[0].a);
      check("out_data", out_data, oq[0].b);
    end
    check("rsp_out_valid", rsp_out_valid, rq.size() != 0);
    if (rq.size() != 0) begin
      check("rsp_out_idx", rsp_out_idx, rq[0].a);
      check("rsp_out_data", rsp_out_data, rq[0].b);
    end
    check("count", count, mcnt);
    check("full", full, mcnt == SZ);
    check("empty", empty, mcnt == 0);
  endtask

  // One clock: predict handshakes from the driven inputs, then compare.
  task automatic step();
    logic [NR-1:0] exp_rdy;
    bit g;
    bit rf;
    bit rrdy;
    int gi;
    int slot;
    @(negedge clk);
    if (reset) begin
      @(posedge clk);
      #1;
      model_clear();
      check_outputs();
      return;
    end
    exp_rdy = '0;
    g = 1'b0;
    gi = 0;
    slot = 0;
    if (req_valid != 0 && mcnt != SZ && (oq.size() == 0 || out_ready)) begin
      for (int i = 0; i < NR; i++) begin
        if (!g && req_valid[(mrr + i) % NR]) begin
          g = 1'b1;
          gi = (mrr + i) % NR;
        end
      end
      for (int s = SZ - 1; s >= 0; s--) if (!mbusy[s]) slot = s;
      exp_rdy[gi] = 1'b1;
    end
    rrdy = (rq.size() == 0) || rsp_out_ready;
    rf   = rsp_valid && rrdy;
    check("req_ready", req_ready, exp_rdy);
    check("rsp_ready", rsp_ready, rrdy);
    if (oq.size() != 0 && out_ready) void'(oq.pop_front());
    if (rq.size() != 0 && rsp_out_ready) void'(rq.pop_front());
    if (rf) begin
      rq.push_back('{a: mt_idx[rsp_tag], b: mt_dat[rsp_tag]});
      mbusy[rsp_tag] = 1'b0;
      mcnt--;
    end
    if (g) begin
      mt_idx[slot] = gi;
      mt_dat[slot] = int'(req_data[gi*DW +: DW]);
      mbusy[slot]  = 1'b1;
      mcnt++;
      mrr = (gi + 1) % NR;
      oq.push_back('{a: slot, b: int'(req_data[gi*DW +: DW])});
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic pick_busy(output int tag, output bit ok);
    int list[$];
    for (int i = 0; i < SZ; i++) if (mbusy[i]) list.push_back(i);
    ok  = list.size() != 0;
    tag = ok ? list[$urandom_range(0, list.size() - 1)] : 0;
  endtask

  initial begin
    int  t;
    bit  ok;
    int  drain_tags[4] = '{0, 1, 3, 2};
    vectors = 0;
    miscompares = 0;
    model_clear();
    reset = 1'b1;
    req_valid = '0;
    req_data = 32'hA3A2A1A0;
    out_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_tag = '0;
    rsp_out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    // All requesters valid: grants 0..3 take tags 0..3, then full.
    req_valid = 4'hF;
    repeat (6) step();
    check("full_after_4", full, 1);
    check("count_after_4", count, 4);

    // Release tag 2 while full: no grant that cycle, tag 2 reused next.
    rsp_valid = 1'b1;
    rsp_tag = 2'd2;
    step();
    rsp_valid = 1'b0;
    check("rsp_idx_tag2", rsp_out_idx, 2);
    check("rsp_data_tag2", rsp_out_data, 8'hA2);
    step();
    check("regrant_tag2", out_tag, 2);
    req_valid = '0;
    step();
    foreach (drain_tags[i]) begin
      rsp_valid = 1'b1;
      rsp_tag = AW'(drain_tags[i]);
      step();
      rsp_valid = 1'b0;
      step();
    end
    check("drained_empty", empty, 1);

    // Downstream back-pressure holds the out stage.
    req_valid = 4'h1;
    out_ready = 1'b0;
    repeat (4) step();
    check("bp_count", count, 1);
    check("bp_data", out_data, 8'hA0);
    req_valid = '0;
    out_ready = 1'b1;
    step();

    // Allocate tag 1 while releasing tag 0.
    req_valid = 4'h2;
    rsp_valid = 1'b1;
    rsp_tag = 2'd0;
    step();
    rsp_valid = 1'b0;
    check("swap_count", count, 1);
    check("swap_tag", out_tag, 1);
    step();
    check("reuse_tag0", out_tag, 0);
    req_valid = '0;
    step();

    // Random traffic against the scoreboard.
    for (int c = 0; c < 400; c++) begin
      req_valid = NR'($urandom);
      req_data = $urandom;
      out_ready = $urandom_range(0, 3) != 0;
      rsp_out_ready = $urandom_range(0, 3) != 0;
      pick_busy(t, ok);
      rsp_valid = ok && ($urandom_range(0, 1) == 1);
      rsp_tag = AW'(t);
      step();
    end

    // Reset mid-operation with count=3 and a pending routed response.
    reset = 1'b1;
    rsp_valid = 1'b0;
    step();
    reset = 1'b0;
    req_data = 32'hA3A2A1A0;
    out_ready = 1'b1;
    rsp_out_ready = 1'b1;
    req_valid = 4'h6;
    repeat (4) step();
    req_valid = '0;
    rsp_out_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_tag = 2'd1;
    step();
    rsp_valid = 1'b0;
    check("pre_reset_count", count, 3);
    check("pre_reset_rspv", rsp_out_valid, 1);
    reset = 1'b1;
    step();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_rspv", rsp_out_valid, 0);
    check("rst_outv", out_valid, 0);
    reset = 1'b0;
    rsp_out_ready = 1'b1;
    req_valid = 4'hF;
    step();
    check("rst_rr_data", out_data, 8'hA0);
    req_valid = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
